// File: rtl/jtdd_sdram_arb.sv
// SDRAM arbiter for JTDD: download writes take absolute priority, otherwise four ROM
// readers share the port round-robin. A watchdog aborts any wait the controller never ends.
module jtdd_sdram_arb #(
    parameter logic [7:0] TOUT = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_downloading,
    input  logic        i_prog_we,
    input  logic [21:0] i_prog_addr,
    input  logic [7:0]  i_prog_data,
    input  logic [1:0]  i_prog_mask,
    output logic        o_prog_ack,
    input  logic [3:0]  i_rd_req,
    input  logic [87:0] i_rd_addr,
    output logic [3:0]  o_rd_ok,
    output logic [15:0] o_rd_data,
    output logic        o_sdram_req,
    output logic        o_sdram_wr,
    output logic [21:0] o_sdram_addr,
    output logic [15:0] o_sdram_din,
    output logic [1:0]  o_sdram_mask,
    input  logic        i_sdram_ack,
    input  logic        i_sdram_rdy,
    input  logic [15:0] i_sdram_dout,
    output logic        o_busy,
    output logic        o_tout_err
);

    typedef enum logic [1:0] {StIdle, StWaitAck, StWaitRdy} state_t;

    state_t      r_state, w_state_nx;
    logic [7:0]  r_cnt, w_cnt_nx;
    logic [1:0]  r_last, w_last_nx;
    logic        r_req, w_req_nx;
    logic        r_wr, w_wr_nx;
    logic [21:0] r_addr, w_addr_nx;
    logic [15:0] r_din, w_din_nx;
    logic [1:0]  r_mask, w_mask_nx;
    logic        r_prog_ack, w_prog_ack_nx;
    logic [3:0]  r_rd_ok, w_rd_ok_nx;
    logic [15:0] r_rd_data, w_rd_data_nx;
    logic        r_tout_err, w_tout_err_nx;

    logic        w_found;
    logic [1:0]  w_pick, w_idx;
    logic [21:0] w_pick_addr;
    logic        w_timeout;

    // First pending requester searching upward from last+1, wrapping at 4.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = r_last;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && i_rd_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        unique case (w_pick)
            2'd0:    w_pick_addr = i_rd_addr[21:0];
            2'd1:    w_pick_addr = i_rd_addr[43:22];
            2'd2:    w_pick_addr = i_rd_addr[65:44];
            default: w_pick_addr = i_rd_addr[87:66];
        endcase
    end

    assign w_timeout = (8'(r_cnt + 8'd1) == TOUT);

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt + 8'd1;
        w_last_nx     = r_last;
        w_req_nx      = r_req;
        w_wr_nx       = r_wr;
        w_addr_nx     = r_addr;
        w_din_nx      = r_din;
        w_mask_nx     = r_mask;
        w_prog_ack_nx = 1'b0;
        w_rd_ok_nx    = 4'd0;
        w_rd_data_nx  = r_rd_data;
        w_tout_err_nx = r_tout_err;
        unique case (r_state)
            StIdle: begin
                w_cnt_nx = 8'd0;
                if (i_downloading && i_prog_we) begin
                    w_wr_nx    = 1'b1;
                    w_addr_nx  = i_prog_addr;
                    w_din_nx   = {i_prog_data, i_prog_data};
                    w_mask_nx  = i_prog_mask;
                    w_req_nx   = 1'b1;
                    w_state_nx = StWaitAck;
                end else if (!i_downloading && w_found) begin
                    w_last_nx  = w_pick;
                    w_addr_nx  = w_pick_addr;
                    w_wr_nx    = 1'b0;
                    w_mask_nx  = 2'b00;
                    w_req_nx   = 1'b1;
                    w_state_nx = StWaitAck;
                end
            end
            StWaitAck: begin
                if (i_sdram_ack) begin
                    w_req_nx = 1'b0;
                    w_cnt_nx = 8'd0;
                    if (r_wr) begin
                        w_prog_ack_nx = 1'b1;
                        w_state_nx    = StIdle;
                    end else if (i_sdram_rdy) begin
                        w_rd_data_nx = i_sdram_dout;
                        w_rd_ok_nx   = 4'b0001 << r_last;
                        w_state_nx   = StIdle;
                    end else begin
                        w_state_nx = StWaitRdy;
                    end
                end else if (w_timeout) begin
                    w_req_nx      = 1'b0;
                    w_tout_err_nx = 1'b1;
                    w_state_nx    = StIdle;
                end
            end
            StWaitRdy: begin
                if (i_sdram_rdy) begin
                    w_rd_data_nx = i_sdram_dout;
                    w_rd_ok_nx   = 4'b0001 << r_last;
                    w_state_nx   = StIdle;
                end else if (w_timeout) begin
                    w_tout_err_nx = 1'b1;
                    w_state_nx    = StIdle;
                end
            end
            default: w_state_nx = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_last     <= 2'd3;
            r_req      <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= 22'd0;
            r_din      <= 16'd0;
            r_mask     <= 2'b00;
            r_prog_ack <= 1'b0;
            r_rd_ok    <= 4'd0;
            r_rd_data  <= 16'd0;
            r_tout_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_last     <= w_last_nx;
            r_req      <= w_req_nx;
            r_wr       <= w_wr_nx;
            r_addr     <= w_addr_nx;
            r_din      <= w_din_nx;
            r_mask     <= w_mask_nx;
            r_prog_ack <= w_prog_ack_nx;
            r_rd_ok    <= w_rd_ok_nx;
            r_rd_data  <= w_rd_data_nx;
            r_tout_err <= w_tout_err_nx;
        end
    end

    assign o_prog_ack   = r_prog_ack;
    assign o_rd_ok      = r_rd_ok;
    assign o_rd_data    = r_rd_data;
    assign o_sdram_req  = r_req;
    assign o_sdram_wr   = r_wr;
    assign o_sdram_addr = r_addr;
    assign o_sdram_din  = r_din;
    assign o_sdram_mask = r_mask;
    assign o_busy       = (r_state != StIdle);
    assign o_tout_err   = r_tout_err;

endmodule

// File: tb/tb_jtdd_sdram_arb.sv
// Bench for jtdd_sdram_arb: table of round-robin reads plus hand-written write, mid-read
// download and watchdog sequences; completions are checked against a scoreboard queue.
module tb_jtdd_sdram_arb;

    localparam logic [7:0] TOUT = 8'd16;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_downloading = 1'b0;
    logic        i_prog_we = 1'b0;
    logic [21:0] i_prog_addr = '0;
    logic [7:0]  i_prog_data = '0;
    logic [1:0]  i_prog_mask = '0;
    logic [3:0]  i_rd_req = '0;
    logic [87:0] i_rd_addr = '0;
    logic        i_sdram_ack = 1'b0;
    logic        i_sdram_rdy = 1'b0;
    logic [15:0] i_sdram_dout = '0;
    logic        o_prog_ack, o_sdram_req, o_sdram_wr, o_busy, o_tout_err;
    logic [3:0]  o_rd_ok;
    logic [15:0] o_rd_data, o_sdram_din;
    logic [21:0] o_sdram_addr;
    logic [1:0]  o_sdram_mask;

    always #5 clk = ~clk;

    jtdd_sdram_arb #(.TOUT(TOUT)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_downloading(i_downloading),
        .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr), .i_prog_data(i_prog_data),
        .i_prog_mask(i_prog_mask), .o_prog_ack(o_prog_ack), .i_rd_req(i_rd_req),
        .i_rd_addr(i_rd_addr), .o_rd_ok(o_rd_ok), .o_rd_data(o_rd_data),
        .o_sdram_req(o_sdram_req), .o_sdram_wr(o_sdram_wr), .o_sdram_addr(o_sdram_addr),
        .o_sdram_din(o_sdram_din), .o_sdram_mask(o_sdram_mask), .i_sdram_ack(i_sdram_ack),
        .i_sdram_rdy(i_sdram_rdy), .i_sdram_dout(i_sdram_dout), .o_busy(o_busy),
        .o_tout_err(o_tout_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_wr;
        logic [3:0]  ok;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0]  req;
        int          gnt;
        logic [15:0] dout;
        int          ack_dly;
        int          rdy_dly;
    } vec_t;
    vec_t vec[9];

    logic [21:0] addr_tab[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input int gnt, input logic [15:0] dout);
        exp_t e;
        e.is_wr = 1'b0;
        e.ok    = 4'b0001 << gnt;
        e.data  = dout;
        sb.push_back(e);
    endtask

    task automatic push_write();
        exp_t e;
        e.is_wr = 1'b1;
        e.ok    = 4'd0;
        e.data  = 16'd0;
        sb.push_back(e);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (o_sdram_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(name, {31'd0, o_sdram_req}, 32'd1);
    endtask

    task automatic finish_read(input int gnt, input logic [15:0] dout, input int ack_dly,
                               input int rdy_dly);
        repeat (ack_dly) step();
        chk("req_held_until_ack", {31'd0, o_sdram_req}, 32'd1);
        i_sdram_ack = 1'b1;
        if (rdy_dly == 0) begin
            i_sdram_rdy  = 1'b1;
            i_sdram_dout = dout;
            push_read(gnt, dout);
        end
        step();
        i_sdram_ack  = 1'b0;
        i_sdram_rdy  = 1'b0;
        i_sdram_dout = 16'hDEAD;
        chk("req_release", {31'd0, o_sdram_req}, 32'd0);
        if (rdy_dly == 0) begin
            chk("same_cycle_no_wait_rdy", {31'd0, o_busy}, 32'd0);
        end else begin
            chk("in_wait_rdy", {31'd0, o_busy}, 32'd1);
            repeat (rdy_dly - 1) step();
            i_sdram_rdy  = 1'b1;
            i_sdram_dout = dout;
            push_read(gnt, dout);
            step();
            i_sdram_rdy  = 1'b0;
            i_sdram_dout = 16'hDEAD;
            chk("read_done_idle", {31'd0, o_busy}, 32'd0);
        end
    endtask

    // Completion monitor: every prog_ack / rd_ok pulse must match the oldest expectation.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (i_rst_n && (o_prog_ack || o_rd_ok != 4'd0)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: prog_ack=%b rd_ok=%b, expected none",
                         o_prog_ack, o_rd_ok);
            end else begin
                e = sb.pop_front();
                chk("done_prog_ack", {31'd0, o_prog_ack}, {31'd0, e.is_wr});
                chk("done_rd_ok", {28'd0, o_rd_ok}, {28'd0, e.ok});
                if (!e.is_wr) chk("done_rd_data", {16'd0, o_rd_data}, {16'd0, e.data});
            end
        end
    end

    initial begin : watchdog_guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        addr_tab[0] = 22'h100000;
        addr_tab[1] = 22'h211111;
        addr_tab[2] = 22'h322222;
        addr_tab[3] = 22'h033333;
        i_rd_addr   = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

        vec[0] = '{4'hF,    0, 16'hA001, 0, 2};
        vec[1] = '{4'hF,    1, 16'hB002, 1, 2};
        vec[2] = '{4'hF,    2, 16'hC003, 2, 2};
        vec[3] = '{4'hF,    3, 16'hD004, 0, 2};
        vec[4] = '{4'hF,    0, 16'hE005, 1, 2};
        vec[5] = '{4'b0100, 2, 16'h1234, 1, 0};
        vec[6] = '{4'b1010, 3, 16'h0F0F, 0, 1};
        vec[7] = '{4'b1010, 1, 16'hF0F0, 2, 3};
        vec[8] = '{4'b0001, 0, 16'h8421, 0, 0};

        // Reset with all readers requesting.
        i_rst_n  = 1'b0;
        i_rd_req = 4'hF;
        repeat (4) step();
        chk("reset_ctrl", {22'd0, o_prog_ack, o_rd_ok, o_sdram_req, o_sdram_wr, o_sdram_mask,
                           o_busy, o_tout_err}, 32'd0);
        chk("reset_data", {o_rd_data, o_sdram_din}, 32'd0);
        chk("reset_addr", {10'd0, o_sdram_addr}, 32'd0);
        i_rst_n = 1'b1;
        step();
        chk("first_req_latency", {31'd0, o_sdram_req}, 32'd1);
        chk("first_grant_req0", {10'd0, o_sdram_addr}, {10'd0, addr_tab[0]});

        for (int k = 0; k < 9; k++) begin
            i_rd_req = vec[k].req;
            wait_req("rr_req");
            chk("rr_grant_addr", {10'd0, o_sdram_addr}, {10'd0, addr_tab[vec[k].gnt]});
            chk("rr_wr_mask", {29'd0, o_sdram_wr, o_sdram_mask}, 32'd0);
            if (k > 0) chk("rd_data_hold", {16'd0, o_rd_data}, {16'd0, vec[k-1].dout});
            finish_read(vec[k].gnt, vec[k].dout, vec[k].ack_dly, vec[k].rdy_dly);
        end
        i_rd_req = 4'd0;

        // Stray ack/rdy while idle.
        step();
        i_sdram_ack  = 1'b1;
        i_sdram_rdy  = 1'b1;
        i_sdram_dout = 16'hBEEF;
        step();
        i_sdram_ack = 1'b0;
        i_sdram_rdy = 1'b0;
        step();
        chk("idle_ignore_busy", {30'd0, o_busy, o_sdram_req}, 32'd0);
        chk("idle_ignore_data", {16'd0, o_rd_data}, 32'h8421);

        // Write request without download is ignored.
        i_prog_we   = 1'b1;
        i_prog_addr = 22'h020010;
        i_prog_data = 8'hA5;
        i_prog_mask = 2'b10;
        repeat (3) step();
        chk("no_write_without_download", {30'd0, o_busy, o_sdram_req}, 32'd0);

        // Download write.
        i_downloading = 1'b1;
        step();
        chk("wr_req_latency", {31'd0, o_sdram_req}, 32'd1);
        chk("wr_flag", {31'd0, o_sdram_wr}, 32'd1);
        chk("wr_addr", {10'd0, o_sdram_addr}, 32'h020010);
        chk("wr_din", {16'd0, o_sdram_din}, 32'hA5A5);
        chk("wr_mask", {30'd0, o_sdram_mask}, 32'd2);
        repeat (2) step();
        chk("wr_no_early_ack", {31'd0, o_prog_ack}, 32'd0);
        i_sdram_ack = 1'b1;
        i_prog_we   = 1'b0;
        push_write();
        step();
        i_sdram_ack = 1'b0;
        chk("prog_ack_pulse", {30'd0, o_prog_ack, o_sdram_req}, 32'd2);
        step();
        chk("prog_ack_once", {30'd0, o_prog_ack, o_busy}, 32'd0);
        i_downloading = 1'b0;

        // Download rises during a read of requester 1; address change after grant.
        i_rd_req = 4'b0010;
        wait_req("mid_rd_req");
        chk("mid_rd_addr", {10'd0, o_sdram_addr}, {10'd0, addr_tab[1]});
        i_rd_addr[43:22] = 22'h3FFFFF;
        i_rd_req         = 4'hF;
        i_downloading    = 1'b1;
        i_prog_we        = 1'b1;
        i_prog_addr      = 22'h0ABCDE;
        i_prog_data      = 8'h3C;
        i_prog_mask      = 2'b01;
        step();
        chk("addr_latched", {10'd0, o_sdram_addr}, {10'd0, addr_tab[1]});
        finish_read(1, 16'h5A5A, 1, 2);
        wait_req("mid_wr_req");
        chk("mid_wr_flag", {31'd0, o_sdram_wr}, 32'd1);
        chk("mid_wr_addr", {10'd0, o_sdram_addr}, 32'h0ABCDE);
        chk("mid_wr_din_mask", {14'd0, o_sdram_din, o_sdram_mask}, {14'd0, 16'h3C3C, 2'b01});
        i_sdram_ack = 1'b1;
        i_prog_we   = 1'b0;
        push_write();
        step();
        i_sdram_ack = 1'b0;
        repeat (3) step();
        chk("no_read_while_download", {30'd0, o_busy, o_sdram_req}, 32'd0);
        i_rd_req      = 4'd0;
        i_downloading = 1'b0;
        i_rd_addr     = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

        // Watchdog: ack withheld.
        i_rd_req = 4'b0100;
        wait_req("wd_req");
        chk("wd_addr", {10'd0, o_sdram_addr}, {10'd0, addr_tab[2]});
        repeat (15) step();
        chk("wd_req_held", {30'd0, o_sdram_req, o_tout_err}, 32'd2);
        step();
        chk("wd_abort", {29'd0, o_sdram_req, o_tout_err, o_busy}, 32'd2);
        step();
        chk("wd_regrant", {31'd0, o_sdram_req}, 32'd1);
        chk("wd_regrant_addr", {10'd0, o_sdram_addr}, {10'd0, addr_tab[2]});
        finish_read(2, 16'h7777, 0, 2);
        i_rd_req = 4'd0;
        step();
        chk("tout_err_sticky", {31'd0, o_tout_err}, 32'd1);
        i_rst_n = 1'b0;
        step();
        chk("tout_err_reset", {30'd0, o_tout_err, o_busy}, 32'd0);
        i_rst_n = 1'b1;
        step();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
